// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection controller.
// The lamp decode lives here so the state/lamp mapping has a single owner.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_t;

    localparam int unsigned LED_W = 3;

    localparam logic [LED_W-1:0] LED_RED = 3'b100;
    localparam logic [LED_W-1:0] LED_AMB = 3'b010;
    localparam logic [LED_W-1:0] LED_GRN = 3'b001;
    localparam logic [LED_W-1:0] LED_OFF = 3'b000;

    typedef struct packed {
        logic [LED_W-1:0] ns;
        logic [LED_W-1:0] ew;
        logic             walk;
    } lamp_t;

    // Moore lamp pattern for a state; flash_on selects the lit half of the flash cycle.
    function automatic lamp_t lamp_decode(input state_t s, input logic flash_on);
        lamp_t l;
        l.ns   = LED_RED;
        l.ew   = LED_RED;
        l.walk = 1'b0;
        case (s)
            NS_GREEN:  l.ns = LED_GRN;
            NS_YELLOW: l.ns = LED_AMB;
            EW_GREEN:  l.ew = LED_GRN;
            EW_YELLOW: l.ew = LED_AMB;
            PED_WALK:  l.walk = 1'b1;
            FLASH: begin
                l.ns = flash_on ? LED_AMB : LED_OFF;
                l.ew = flash_on ? LED_AMB : LED_OFF;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// A synchronous restart realigns the tick to the start of a new phase.
module tl_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick_c
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick_c = (cnt == LAST);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection sequencer with pedestrian phase and maintenance flash.
// Lamps are registered from the next-state decode, so they track the state register with no lag.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned GREEN_T     = 55,
    parameter int unsigned YELLOW_T    = 8,
    parameter int unsigned ALLRED_T    = 2,
    parameter int unsigned WALK_T      = 10,
    parameter int unsigned MIN_GREEN_T = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ped_btn,
    input  logic             maint,
    output logic [LED_W-1:0] ns_led,
    output logic [LED_W-1:0] ew_led,
    output logic             walk,
    output logic             ped_wait,
    output logic [2:0]       phase
);

    localparam int unsigned MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int unsigned MAX_AW = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int unsigned MAX_T  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
    localparam int unsigned PW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [PW-1:0] GREEN_LAST  = PW'(GREEN_T - 1);
    localparam logic [PW-1:0] YELLOW_LAST = PW'(YELLOW_T - 1);
    localparam logic [PW-1:0] ALLRED_LAST = PW'(ALLRED_T - 1);
    localparam logic [PW-1:0] WALK_LAST   = PW'(WALK_T - 1);
    localparam logic [PW-1:0] MIN_LAST    = PW'(MIN_GREEN_T - 1);

    state_t        state, state_nx;
    dir_t          next_dir, next_dir_nx;
    logic [PW-1:0] phase_cnt;
    logic          ped_pending, ped_pending_nx;
    logic          flash_on, flash_nx;
    logic          btn_meta, btn_sync, btn_prev;
    logic          ped_rise_c;
    logic          tick_c;
    logic          restart_c;
    logic          green_end_c;
    lamp_t         lamp_nx;

    tl_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart_c),
        .tick_c (tick_c)
    );

    // Button synchroniser and rising-edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= ped_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign ped_rise_c = btn_sync & ~btn_prev;

    // A pending request lets green end early once the minimum green has elapsed.
    assign green_end_c = tick_c &&
                         ((phase_cnt == GREEN_LAST) || (ped_pending && (phase_cnt >= MIN_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ALL_RED_A;
            next_dir    <= NS;
            phase_cnt   <= '0;
            ped_pending <= 1'b0;
            flash_on    <= 1'b0;
            ns_led      <= LED_RED;
            ew_led      <= LED_RED;
            walk        <= 1'b0;
        end else begin
            state       <= state_nx;
            next_dir    <= next_dir_nx;
            ped_pending <= ped_pending_nx;
            flash_on    <= flash_nx;
            ns_led      <= lamp_nx.ns;
            ew_led      <= lamp_nx.ew;
            walk        <= lamp_nx.walk;
            if (restart_c) begin
                phase_cnt <= '0;
            end else if (tick_c && (state != FLASH)) begin
                phase_cnt <= phase_cnt + PW'(1);
            end
        end
    end

    always_comb begin
        state_nx       = state;
        next_dir_nx    = next_dir;
        ped_pending_nx = ped_pending;
        flash_nx       = flash_on;

        case (state)
            ALL_RED_A: begin
                next_dir_nx = NS;
                if (tick_c && (phase_cnt == ALLRED_LAST)) begin
                    state_nx = ped_pending ? PED_WALK : NS_GREEN;
                end
            end
            NS_GREEN: begin
                if (green_end_c) state_nx = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (tick_c && (phase_cnt == YELLOW_LAST)) state_nx = ALL_RED_B;
            end
            ALL_RED_B: begin
                next_dir_nx = EW;
                if (tick_c && (phase_cnt == ALLRED_LAST)) begin
                    state_nx = ped_pending ? PED_WALK : EW_GREEN;
                end
            end
            EW_GREEN: begin
                if (green_end_c) state_nx = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (tick_c && (phase_cnt == YELLOW_LAST)) state_nx = ALL_RED_A;
            end
            PED_WALK: begin
                if (tick_c && (phase_cnt == WALK_LAST)) begin
                    state_nx = (next_dir == NS) ? NS_GREEN : EW_GREEN;
                end
            end
            FLASH: begin
                next_dir_nx = NS;
                state_nx    = ALL_RED_A;
            end
            default: state_nx = ALL_RED_A;
        endcase

        if (maint) state_nx = FLASH;

        // Requests are consumed on walk entry; edges inside walk or flash are dropped.
        if ((state_nx == PED_WALK) && (state != PED_WALK)) begin
            ped_pending_nx = 1'b0;
        end else if (ped_rise_c && (state != PED_WALK) && (state != FLASH)) begin
            ped_pending_nx = 1'b1;
        end

        if ((state_nx == FLASH) && (state != FLASH)) begin
            flash_nx = 1'b1;
        end else if ((state == FLASH) && tick_c) begin
            flash_nx = ~flash_on;
        end

        restart_c = (state_nx != state);
        lamp_nx   = lamp_decode(state_nx, flash_nx);
    end

    assign phase    = 3'(state);
    assign ped_wait = ped_pending;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with small timing parameters.
// Expected lamp/phase patterns are hand-derived cycle counts for TICK_DIV=4.
module tb_traffic_intersection_ctrl;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] AMB = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [2:0] P_ARA = 3'd0;
    localparam logic [2:0] P_NSG = 3'd1;
    localparam logic [2:0] P_NSY = 3'd2;
    localparam logic [2:0] P_ARB = 3'd3;
    localparam logic [2:0] P_EWG = 3'd4;
    localparam logic [2:0] P_EWY = 3'd5;
    localparam logic [2:0] P_PW  = 3'd6;
    localparam logic [2:0] P_FL  = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ped_btn = 1'b0;
    logic       maint = 1'b0;
    logic [2:0] ns_led;
    logic [2:0] ew_led;
    logic       walk;
    logic       ped_wait;
    logic [2:0] phase;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [2:0] prev_ns = 3'b100;
    logic [2:0] prev_ew = 3'b100;

    traffic_intersection_ctrl #(
        .TICK_DIV   (4),
        .GREEN_T    (5),
        .YELLOW_T   (2),
        .ALLRED_T   (1),
        .WALK_T     (3),
        .MIN_GREEN_T(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ped_btn (ped_btn),
        .maint   (maint),
        .ns_led  (ns_led),
        .ew_led  (ew_led),
        .walk    (walk),
        .ped_wait(ped_wait),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic check_now(input string tag, input logic [2:0] ens, input logic [2:0] eew,
                             input logic ewk, input logic ewt, input logic [2:0] eph);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {ns_led, ew_led, walk, ped_wait, phase};
        exp = {ens, eew, ewk, ewt, eph};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed ns/ew/walk/wait/phase %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Move to the next sampling point and check the lamp safety properties.
    task automatic advance();
        @(negedge clk);
        cyc++;
        n_assert++;
        assert (!((ns_led === GRN) && (ew_led === GRN))) else begin
            n_fail++;
            $error("FAIL both_green cyc %0d: observed ns %b ew %b expected not both %b", cyc, ns_led, ew_led, GRN);
        end
        n_assert++;
        assert (!((prev_ns === GRN) && (ns_led === RED)) && !((prev_ew === GRN) && (ew_led === RED))) else begin
            n_fail++;
            $error("FAIL green_to_red cyc %0d: observed ns %b->%b ew %b->%b expected amber after green",
                   cyc, prev_ns, ns_led, prev_ew, ew_led);
        end
        prev_ns = ns_led;
        prev_ew = ew_led;
    endtask

    task automatic run(input logic [2:0] ens, input logic [2:0] eew, input logic ewk,
                       input logic ewt, input logic [2:0] eph, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_now(tag, ens, eew, ewk, ewt, eph);
            advance();
        end
    endtask

    task automatic full_cycle(input string tag);
        run(RED, RED, 1'b0, 1'b0, P_ARA, 4,  {tag, "_all_red_a"});
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 20, {tag, "_ns_green"});
        run(AMB, RED, 1'b0, 1'b0, P_NSY, 8,  {tag, "_ns_amber"});
        run(RED, RED, 1'b0, 1'b0, P_ARB, 4,  {tag, "_all_red_b"});
        run(RED, GRN, 1'b0, 1'b0, P_EWG, 20, {tag, "_ew_green"});
        run(RED, AMB, 1'b0, 1'b0, P_EWY, 8,  {tag, "_ew_amber"});
    endtask

    initial begin
        // Test 1: reset state and two identical free-running cycles.
        repeat (2) @(negedge clk);
        check_now("reset", RED, RED, 1'b0, 1'b0, P_ARA);
        rst_n = 1'b1;
        full_cycle("t1a");
        full_cycle("t1b");

        // Test 2: one press in the first NS green cycle truncates green and adds a walk.
        run(RED, RED, 1'b0, 1'b0, P_ARA, 4, "t2_all_red_a");
        ped_btn = 1'b1;
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 1, "t2_ns_green_press");
        ped_btn = 1'b0;
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 2,  "t2_ns_green_sync");
        run(GRN, RED, 1'b0, 1'b1, P_NSG, 5,  "t2_ns_green_wait");
        run(AMB, RED, 1'b0, 1'b1, P_NSY, 8,  "t2_ns_amber");
        run(RED, RED, 1'b0, 1'b1, P_ARB, 4,  "t2_all_red_b");
        run(RED, RED, 1'b1, 1'b0, P_PW,  12, "t2_walk");
        run(RED, GRN, 1'b0, 1'b0, P_EWG, 20, "t2_ew_green");
        run(RED, AMB, 1'b0, 1'b0, P_EWY, 8,  "t2_ew_amber");

        // Test 3: long hold plus re-press during walk gives a single walk phase.
        ped_btn = 1'b1;
        run(RED, RED, 1'b0, 1'b0, P_ARA, 3, "t3_all_red_a");
        run(RED, RED, 1'b0, 1'b1, P_ARA, 1, "t3_all_red_a_wait");
        run(RED, RED, 1'b1, 1'b0, P_PW,  2, "t3_walk_held");
        ped_btn = 1'b0;
        run(RED, RED, 1'b1, 1'b0, P_PW,  2, "t3_walk_release");
        ped_btn = 1'b1;
        run(RED, RED, 1'b1, 1'b0, P_PW,  8,  "t3_walk_repress");
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 20, "t3_ns_green_full");
        run(AMB, RED, 1'b0, 1'b0, P_NSY, 4,  "t3_ns_amber_held");
        ped_btn = 1'b0;
        run(AMB, RED, 1'b0, 1'b0, P_NSY, 4,  "t3_ns_amber");
        run(RED, RED, 1'b0, 1'b0, P_ARB, 4,  "t3_all_red_b");
        run(RED, GRN, 1'b0, 1'b0, P_EWG, 10, "t3_ew_green");

        // Test 4: maintenance flash from mid EW green, then recovery via ALL_RED_A.
        maint = 1'b1;
        run(RED, GRN, 1'b0, 1'b0, P_EWG, 1, "t4_ew_green_last");
        run(AMB, AMB, 1'b0, 1'b0, P_FL,  4, "t4_flash_on0");
        run(OFF, OFF, 1'b0, 1'b0, P_FL,  4, "t4_flash_off0");
        run(AMB, AMB, 1'b0, 1'b0, P_FL,  4, "t4_flash_on1");
        maint = 1'b0;
        run(OFF, OFF, 1'b0, 1'b0, P_FL,  1, "t4_flash_exit");
        run(RED, RED, 1'b0, 1'b0, P_ARA, 4, "t4_all_red_a");

        // Test 5: asynchronous reset in the middle of a walk.
        ped_btn = 1'b1;
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 1, "t5_ns_green_press");
        ped_btn = 1'b0;
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 2, "t5_ns_green_sync");
        run(GRN, RED, 1'b0, 1'b1, P_NSG, 5, "t5_ns_green_wait");
        run(AMB, RED, 1'b0, 1'b1, P_NSY, 8, "t5_ns_amber");
        run(RED, RED, 1'b0, 1'b1, P_ARB, 4, "t5_all_red_b");
        run(RED, RED, 1'b1, 1'b0, P_PW,  5, "t5_walk");
        rst_n = 1'b0;
        #1;
        check_now("t5_async_reset", RED, RED, 1'b0, 1'b0, P_ARA);
        @(negedge clk);
        @(negedge clk);
        prev_ns = ns_led;
        prev_ew = ew_led;
        rst_n = 1'b1;
        full_cycle("t5");

        // Test 6: sub-cycle glitching on the button registers one request only.
        run(RED, RED, 1'b0, 1'b0, P_ARA, 4, "t6_all_red_a");
        check_now("t6_ns_green_first", GRN, RED, 1'b0, 1'b0, P_NSG);
        #1 ped_btn = 1'b1;
        #1 ped_btn = 1'b0;
        #1 ped_btn = 1'b1;
        #3 ped_btn = 1'b0;
        #1 ped_btn = 1'b1;
        #1 ped_btn = 1'b0;
        advance();
        run(GRN, RED, 1'b0, 1'b0, P_NSG, 2,  "t6_ns_green_sync");
        run(GRN, RED, 1'b0, 1'b1, P_NSG, 5,  "t6_ns_green_wait");
        run(AMB, RED, 1'b0, 1'b1, P_NSY, 8,  "t6_ns_amber");
        run(RED, RED, 1'b0, 1'b1, P_ARB, 4,  "t6_all_red_b");
        run(RED, RED, 1'b1, 1'b0, P_PW,  12, "t6_walk");
        run(RED, GRN, 1'b0, 1'b0, P_EWG, 4,  "t6_ew_green");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
